// File: rtl/pe_link_tx.sv
// rtl/pe_link_tx.sv - transmit end of the inter-PE link: beat FIFO plus credit-gated registered link word
// The link word is {valid, last, data}; a beat always spends at least one edge in the FIFO before it is sent.
module pe_link_tx #(
  parameter int AXIS_WIDTH = 128,
  parameter int LINK_WIDTH = 130,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter int CNT_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [AXIS_WIDTH-1:0] din,
  input  logic                  din_last,
  input  logic                  val_in,
  output logic                  ready_upward,
  output logic [LINK_WIDTH-1:0] out_to_link,
  input  logic                  credit_in,
  output logic [CNT_BITS-1:0]   credit_count,
  output logic                  credit_err,
  output logic                  idle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C   = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] CREDITS_C = CNT_BITS'(CREDITS);

  logic [AXIS_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_BITS-1:0]   occupancy;
  logic                  accept;
  logic                  send;
  logic                  credit_sat;

  // Gating with reset keeps ready low during reset even though occupancy is already zero.
  assign ready_upward = reset && ap_start && (occupancy < DEPTH_C);
  assign accept       = val_in && ready_upward;
  assign send         = ap_start && (occupancy != '0) && (credit_count != '0);
  assign credit_sat   = credit_in && !send && (credit_count == CREDITS_C);
  assign idle         = (occupancy == '0) && (credit_count == CREDITS_C);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= {din_last, din};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (send) begin
        rptr <= rptr + 1'b1;
      end
      case ({accept, send})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_count <= CREDITS_C;
      credit_err   <= 1'b0;
    end else begin
      if (credit_sat) begin
        credit_err <= 1'b1;
      end else begin
        case ({send, credit_in})
          2'b10:   credit_count <= credit_count - 1'b1;
          2'b01:   credit_count <= credit_count + 1'b1;
          default: credit_count <= credit_count;
        endcase
      end
    end
  end

  // Only the valid bit drops on idle cycles; last/data keep the previous beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_to_link <= '0;
    end else if (send) begin
      out_to_link <= {1'b1, mem[rptr]};
    end else begin
      out_to_link[LINK_WIDTH-1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_link_tx.sv
// tb/tb_pe_link_tx.sv - scoreboard bench for pe_link_tx with directed vectors
module tb_pe_link_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [127:0] din;
  logic         din_last;
  logic         val_in;
  logic         ready_upward;
  logic [129:0] out_to_link;
  logic         credit_in;
  logic [2:0]   credit_count;
  logic         credit_err;
  logic         idle;

  int checks   = 0;
  int failures = 0;
  logic [129:0] exp_q [$];

  pe_link_tx dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(din), .din_last(din_last),
    .val_in(val_in), .ready_upward(ready_upward), .out_to_link(out_to_link),
    .credit_in(credit_in), .credit_count(credit_count), .credit_err(credit_err), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input logic l);
    val_in   = 1'b1;
    din      = d;
    din_last = l;
    exp_q.push_back({1'b1, l, d});
  endtask

  // Monitor: every valid link word must match the next expected beat.
  always @(negedge clk) begin
    if (reset && out_to_link[129]) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL link_unexpected: got %h expected no beat", out_to_link);
      end else begin
        logic [129:0] e;
        e = exp_q.pop_front();
        if (out_to_link !== e) begin
          failures++;
          $display("FAIL link_beat: got %h expected %h", out_to_link, e);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ap_start = 1'b0; din = '0; din_last = 1'b0; val_in = 1'b0; credit_in = 1'b0;
    repeat (3) tick();
    check("rst_ready", 130'(ready_upward), 130'(0));
    check("rst_link", out_to_link, 130'(0));
    check("rst_credit", 130'(credit_count), 130'(4));
    reset = 1'b1; ap_start = 1'b1;
    tick();
    check("idle_credit", 130'(credit_count), 130'(4));
    check("idle_idle", 130'(idle), 130'(1));
    check("idle_ready", 130'(ready_upward), 130'(1));
    check("idle_link", out_to_link, 130'(0));

    // single beat
    push(128'hA5, 1'b1);
    tick();
    val_in = 1'b0;
    check("single_not_yet", 130'(out_to_link[129]), 130'(0));
    tick();
    check("single_link", out_to_link, {2'b11, 128'hA5});
    check("single_credit", 130'(credit_count), 130'(3));
    check("single_idle", 130'(idle), 130'(0));
    tick();
    check("single_one_cycle", 130'(out_to_link[129]), 130'(0));
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("single_restore", 130'(credit_count), 130'(4));
    check("single_idle_back", 130'(idle), 130'(1));

    // credit starvation
    for (int i = 0; i < 8; i++) begin
      push(128'(i), i == 7);
      tick();
    end
    val_in = 1'b0;
    check("starve_credit", 130'(credit_count), 130'(0));
    check("starve_ready", 130'(ready_upward), 130'(0));
    repeat (3) tick();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("starve_no_send_yet", 130'(out_to_link[129]), 130'(0));
    tick();
    check("starve_beat4", out_to_link, {2'b10, 128'd4});
    check("starve_credit0", 130'(credit_count), 130'(0));
    check("starve_ready_back", 130'(ready_upward), 130'(1));

    // simultaneous accept, send and credit return at occupancy 2, credit 1
    credit_in = 1'b1;
    tick();
    tick();
    check("simul_pre_credit", 130'(credit_count), 130'(1));
    push(128'd8, 1'b0);
    tick();
    val_in = 1'b0;
    check("simul_credit", 130'(credit_count), 130'(1));
    check("simul_ready", 130'(ready_upward), 130'(1));
    repeat (5) tick();
    credit_in = 1'b0;
    check("simul_drain_credit", 130'(credit_count), 130'(4));
    check("simul_drain_idle", 130'(idle), 130'(1));
    check("simul_drain_q", 130'(exp_q.size()), 130'(0));

    // credit overflow
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("ovf_credit", 130'(credit_count), 130'(4));
    check("ovf_err", 130'(credit_err), 130'(1));
    repeat (3) tick();
    check("ovf_sticky", 130'(credit_err), 130'(1));

    // pause with three beats queued and no credits
    for (int i = 0; i < 4; i++) begin
      push(128'h20 + 128'(i), i == 3);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      push(128'h10 + 128'(i), i == 2);
      tick();
    end
    val_in = 1'b0;
    ap_start = 1'b0;
    check("pause_credit0", 130'(credit_count), 130'(0));
    for (int i = 0; i < 5; i++) begin
      credit_in = (i < 4);
      tick();
      check("pause_valid", 130'(out_to_link[129]), 130'(0));
      check("pause_ready", 130'(ready_upward), 130'(0));
    end
    credit_in = 1'b0;
    check("pause_credit_back", 130'(credit_count), 130'(4));
    check("pause_not_idle", 130'(idle), 130'(0));
    ap_start = 1'b1;
    tick();
    check("resume_first", out_to_link, {2'b10, 128'h10});
    repeat (3) tick();
    check("resume_credit", 130'(credit_count), 130'(1));
    check("resume_q", 130'(exp_q.size()), 130'(0));

    // reset mid-packet
    push(128'h30, 1'b0);
    tick();
    push(128'h31, 1'b0);
    tick();
    val_in = 1'b0;
    exp_q.pop_back();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_link", out_to_link, 130'(0));
    check("mid_rst_idle", 130'(idle), 130'(1));
    check("mid_rst_ready", 130'(ready_upward), 130'(0));
    check("mid_rst_err", 130'(credit_err), 130'(0));
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_credit", 130'(credit_count), 130'(4));
    check("post_rst_valid", 130'(out_to_link[129]), 130'(0));
    check("post_rst_q", 130'(exp_q.size()), 130'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
